// File: rtl/mem_pkg.sv
// Shared types and defaults for the burst memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int DEF_LATENCY     = 4;
  localparam int DEF_BLOCK_WORDS = 8;

  // Number of low byte-address bits cleared to align a burst to its block.
  function automatic int blk_off_w(input int block_words);
    return $clog2(block_words) + 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WORDS = 32768,
  localparam int IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_burst_responder.sv
// Multi-cycle memory responder: single writes, single or block reads after a fixed latency.
// Request handshake: a request transfers on a rising edge where req_valid & req_ready; responses have no backpressure.
module mem_burst_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic                  req_burst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_last,
  output logic                  busy
);

  localparam int OFF_W  = blk_off_w(BLOCK_WORDS);
  localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = {ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [LAT_W-1:0]      LAT_LOAD  = LAT_W'(LATENCY - 1);

  state_t                state, state_nx;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [ADDR_WIDTH-1:0] start_addr, beat_addr, addr_q;
  logic [DATA_WIDTH-1:0] data_q, rd_data;
  logic                  burst_q, accept, is_last, wr_en;
  logic                  unused_addr_bits;

  assign accept    = req_valid & req_ready;
  assign beat_addr = start_addr + ADDR_WIDTH'({beat_cnt, 1'b0});
  assign is_last   = burst_q ? (beat_cnt == LAST_BEAT) : 1'b1;
  // Reset wins over a same-cycle accept, so a write never lands during rst.
  assign wr_en     = accept & req_wr & ~rst;
  assign unused_addr_bits = ^{req_addr, beat_addr};

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_idx (req_addr[IDX_W:1]),
    .wr_data(req_wdata),
    .rd_idx (beat_addr[IDX_W:1]),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !req_wr) state_nx = (LATENCY == 1) ? STREAM : WAIT;
      // Counter was loaded with LATENCY-1; leaving at 1 lands the first beat at T+LATENCY.
      WAIT:    if (lat_cnt <= LAT_W'(1)) state_nx = STREAM;
      STREAM:  if (is_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt    <= '0;
      beat_cnt   <= '0;
      start_addr <= '0;
      burst_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !req_wr) begin
            lat_cnt    <= LAT_LOAD;
            beat_cnt   <= '0;
            burst_q    <= req_burst;
            start_addr <= req_burst ? (req_addr & BLK_MASK)
                                    : {req_addr[ADDR_WIDTH-1:1], 1'b0};
          end
        end
        WAIT: lat_cnt <= lat_cnt - 1'b1;
        STREAM: begin
          beat_cnt <= beat_cnt + 1'b1;
          addr_q   <= beat_addr;
          data_q   <= rd_data;
        end
        default: ;
      endcase
    end
  end

  // Outside STREAM the response bus shows the last beat delivered.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state == WAIT) || (state == STREAM);
    rsp_valid = (state == STREAM);
    rsp_last  = (state == STREAM) && is_last;
    rsp_addr  = (state == STREAM) ? beat_addr : addr_q;
    rsp_data  = (state == STREAM) ? rd_data : data_q;
  end

endmodule
